// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits
// beside the forwarding unit and handles the hazards forwarding cannot:
//   * load-use hazards  -> hold PC and IF/ID, inject a bubble into ID/EXE
//   * taken branch/jump -> flush the wrong-path instructions in IF/ID (and
//                          ID/EXE on the resolving cycle)
//   * memory busywait   -> freeze the whole pipeline
// It also keeps a saturating stall counter and a sticky memory-timeout flag.
//
// Control outputs are Mealy (combinational from state + inputs) so a hazard
// is acted on in the same cycle it is detected.
//
// Parameters:
//   FLUSH_CYCLES     IF/ID flush cycles after a taken branch (1..7)
//   LU_STALL_CYCLES  bubble cycles per load-use hazard (1..7)
//   MEM_TIMEOUT      consecutive freeze cycles before TIMEOUT_ERR (1..255)
//   CNT_W            STALL_COUNT width
//
// Ports:
//   CLK, RESET                  clock (rising edge), async active-high reset
//   ID_RS1/ID_RS2               source registers of the ID instruction
//   ID_USES_RS1/ID_USES_RS2     ID instruction really reads RS1/RS2
//   EXE_RD                      destination register of the EXE instruction
//   EXE_MEM_READ, EXE_REG_WRITE EXE instruction is a load / writes the RF
//   BRANCH_TAKEN                branch/jump resolved taken in EXE
//   IMEM_BUSYWAIT, DMEM_BUSYWAIT memory not ready
//   FREEZE                      hold PC and all pipeline registers
//   PC_HOLD, IF_ID_HOLD         hold PC / IF-ID register
//   ID_EXE_BUBBLE               load NOP into ID/EXE
//   IF_ID_FLUSH, ID_EXE_FLUSH   clear the register to NOP
//   STATE                       RUN=00, LU_STALL=01, MEM_WAIT=10, FLUSH=11
//   STALL_COUNT                 cycles with FREEZE or PC_HOLD (saturating)
//   TIMEOUT_ERR                 sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES    = 2,
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       EXE_RD,
    input  logic             EXE_MEM_READ,
    input  logic             EXE_REG_WRITE,
    input  logic             BRANCH_TAKEN,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    output logic             FREEZE,
    output logic             PC_HOLD,
    output logic             IF_ID_HOLD,
    output logic             ID_EXE_BUBBLE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EXE_FLUSH,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic             TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_FLUSH    = 2'b11
    } state_t;

    // Counter reload values: the detecting cycle is the first bubble/flush
    // cycle, so the down-counter only covers the remaining ones.
    localparam logic [2:0] FLUSH_RELOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] LU_RELOAD     = 3'(LU_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             timeout_err_q, timeout_err_d;

    // Unmasked control decisions (masked by RESET at the ports)
    logic freeze_c;
    logic pc_hold_c;
    logic if_id_hold_c;
    logic id_exe_bubble_c;
    logic if_id_flush_c;
    logic id_exe_flush_c;

    // -----------------------------------------------------------------------
    // Load-use detection, one comparator per source operand
    // -----------------------------------------------------------------------
    logic [1:0][4:0] id_rs;
    logic [1:0]      id_uses;
    logic [1:0]      src_hit;
    logic            exe_is_load_wr;
    logic            lu_hit;
    logic            bw;

    assign id_rs   = {ID_RS2, ID_RS1};
    assign id_uses = {ID_USES_RS2, ID_USES_RS1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = id_uses[gi] && (id_rs[gi] == EXE_RD);
    end

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign exe_is_load_wr = EXE_MEM_READ && EXE_REG_WRITE && (EXE_RD != 5'd0);
    assign lu_hit         = exe_is_load_wr && (|src_hit);
    assign bw             = IMEM_BUSYWAIT || DMEM_BUSYWAIT;

    // -----------------------------------------------------------------------
    // Next-state and control outputs. Priority everywhere: BW > branch > LU.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        freeze_c        = 1'b0;
        pc_hold_c       = 1'b0;
        if_id_hold_c    = 1'b0;
        id_exe_bubble_c = 1'b0;
        if_id_flush_c   = 1'b0;
        id_exe_flush_c  = 1'b0;

        case (state_q)
            // MEM_WAIT without busywait behaves exactly like RUN.
            ST_RUN, ST_MEM_WAIT: begin
                if (bw) begin
                    freeze_c = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else if (BRANCH_TAKEN) begin
                    if_id_flush_c  = 1'b1;
                    id_exe_flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (lu_hit) begin
                    pc_hold_c       = 1'b1;
                    if_id_hold_c    = 1'b1;
                    id_exe_bubble_c = 1'b1;
                    if (LU_STALL_CYCLES > 1) begin
                        state_d = ST_LU_STALL;
                        cnt_d   = LU_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            // EXE holds a bubble here, so a branch cannot resolve.
            ST_LU_STALL: begin
                if (bw) begin
                    freeze_c = 1'b1;
                end else begin
                    pc_hold_c       = 1'b1;
                    if_id_hold_c    = 1'b1;
                    id_exe_bubble_c = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end

            // Only IF/ID still carries wrong-path instructions after the
            // resolving cycle; branch and load-use inputs are stale here.
            ST_FLUSH: begin
                if (bw) begin
                    freeze_c = 1'b1;
                end else begin
                    if_id_flush_c = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Wait / timeout / stall counters
    // -----------------------------------------------------------------------
    always_comb begin
        wait_cnt_d    = 8'd0;
        timeout_err_d = timeout_err_q;
        stall_count_d = stall_count_q;

        // Counts consecutive freeze cycles only; any free cycle restarts it.
        if (freeze_c) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end

        // Sticky: once set only RESET clears it; the pipeline keeps waiting.
        if (freeze_c && (wait_cnt_d == TIMEOUT_LIMIT)) begin
            timeout_err_d = 1'b1;
        end

        if ((freeze_c || pc_hold_c) && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_RUN;
            cnt_q         <= 3'd0;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: controls are masked while RESET is high so a reset between
    // clock edges silences the pipeline immediately.
    // -----------------------------------------------------------------------
    assign FREEZE        = freeze_c        && !RESET;
    assign PC_HOLD       = pc_hold_c       && !RESET;
    assign IF_ID_HOLD    = if_id_hold_c    && !RESET;
    assign ID_EXE_BUBBLE = id_exe_bubble_c && !RESET;
    assign IF_ID_FLUSH   = if_id_flush_c   && !RESET;
    assign ID_EXE_FLUSH  = id_exe_flush_c  && !RESET;
    assign STATE         = state_q;
    assign STALL_COUNT   = stall_count_q;
    assign TIMEOUT_ERR   = timeout_err_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Directed bench. Two instances share the same stimulus:
//   dut_a : FLUSH_CYCLES=2, LU_STALL_CYCLES=1, MEM_TIMEOUT=255
//   dut_b : FLUSH_CYCLES=1, LU_STALL_CYCLES=3, MEM_TIMEOUT=5
// Inputs change 1 ns after a rising edge; outputs are checked later in the
// same cycle, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, exe_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       exe_mem_read, exe_reg_write, branch_taken;
    logic       imem_busywait, dmem_busywait;

    logic             a_freeze, a_pc_hold, a_if_id_hold, a_id_exe_bubble;
    logic             a_if_id_flush, a_id_exe_flush, a_timeout_err;
    logic [1:0]       a_state;
    logic [CNT_W-1:0] a_stall_count;

    logic             b_freeze, b_pc_hold, b_if_id_hold, b_id_exe_bubble;
    logic             b_if_id_flush, b_id_exe_flush, b_timeout_err;
    logic [1:0]       b_state;
    logic [CNT_W-1:0] b_stall_count;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .FLUSH_CYCLES(2), .LU_STALL_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(CNT_W)
    ) dut_a (
        .CLK(clk), .RESET(rst),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
        .EXE_RD(exe_rd), .EXE_MEM_READ(exe_mem_read), .EXE_REG_WRITE(exe_reg_write),
        .BRANCH_TAKEN(branch_taken),
        .IMEM_BUSYWAIT(imem_busywait), .DMEM_BUSYWAIT(dmem_busywait),
        .FREEZE(a_freeze), .PC_HOLD(a_pc_hold), .IF_ID_HOLD(a_if_id_hold),
        .ID_EXE_BUBBLE(a_id_exe_bubble),
        .IF_ID_FLUSH(a_if_id_flush), .ID_EXE_FLUSH(a_id_exe_flush),
        .STATE(a_state), .STALL_COUNT(a_stall_count), .TIMEOUT_ERR(a_timeout_err)
    );

    pipeline_hazard_controller #(
        .FLUSH_CYCLES(1), .LU_STALL_CYCLES(3), .MEM_TIMEOUT(5), .CNT_W(CNT_W)
    ) dut_b (
        .CLK(clk), .RESET(rst),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
        .EXE_RD(exe_rd), .EXE_MEM_READ(exe_mem_read), .EXE_REG_WRITE(exe_reg_write),
        .BRANCH_TAKEN(branch_taken),
        .IMEM_BUSYWAIT(imem_busywait), .DMEM_BUSYWAIT(dmem_busywait),
        .FREEZE(b_freeze), .PC_HOLD(b_pc_hold), .IF_ID_HOLD(b_if_id_hold),
        .ID_EXE_BUBBLE(b_id_exe_bubble),
        .IF_ID_FLUSH(b_if_id_flush), .ID_EXE_FLUSH(b_id_exe_flush),
        .STATE(b_state), .STALL_COUNT(b_stall_count), .TIMEOUT_ERR(b_timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; exe_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        exe_mem_read = 1'b0; exe_reg_write = 1'b0; branch_taken = 1'b0;
        imem_busywait = 1'b0; dmem_busywait = 1'b0;
    endtask

    // Load in EXE writing x<rd>; ID reads it through RS2.
    task automatic set_lu_rs2(input logic [4:0] rd);
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_rd = rd;
        id_uses_rs2 = 1'b1; id_rs2 = rd;
    endtask

    initial begin
        // ---------------- Reset ----------------
        clear_inputs();
        rst = 1'b1;
        branch_taken = 1'b1;
        set_lu_rs2(5'd1);
        #2;
        check("rst_mask_if_id_flush", a_if_id_flush, 0);
        check("rst_mask_pc_hold", a_pc_hold, 0);
        tick();
        tick();
        check("rst_state", a_state, 0);
        check("rst_stall_count", a_stall_count, 0);
        check("rst_timeout", a_timeout_err, 0);
        check("rst_freeze", a_freeze, 0);
        clear_inputs();
        rst = 1'b0;
        tick();

        // ---------------- Load-use ----------------
        set_lu_rs2(5'd1);
        #1;
        check("lu_pc_hold", a_pc_hold, 1);
        check("lu_if_id_hold", a_if_id_hold, 1);
        check("lu_bubble", a_id_exe_bubble, 1);
        check("lu_no_freeze", a_freeze, 0);
        check("lu_no_flush", a_if_id_flush, 0);
        tick();
        clear_inputs();
        #1;
        check("lu_a_state_after", a_state, 0);
        check("lu_a_stall_count", a_stall_count, 1);
        check("lu_a_hold_released", a_pc_hold, 0);
        check("lu_b_state_stall", b_state, 1);
        check("lu_b_pc_hold_cont", b_pc_hold, 1);
        tick();
        check("lu_b_state_stall2", b_state, 1);
        tick();
        check("lu_b_state_run", b_state, 0);
        check("lu_b_stall_count", b_stall_count, 3);
        check("lu_b_hold_released", b_pc_hold, 0);

        // EXE_RD = x0 never stalls
        set_lu_rs2(5'd0);
        #1;
        check("lu_rd0_a_pc_hold", a_pc_hold, 0);
        check("lu_rd0_b_bubble", b_id_exe_bubble, 0);
        // Register matches but ID does not read it
        clear_inputs();
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
        #1;
        check("lu_unused_rs1", a_pc_hold, 0);
        tick();
        clear_inputs();

        // ---------------- Branch (with simultaneous LU hit) ----------------
        branch_taken = 1'b1;
        set_lu_rs2(5'd7);
        #1;
        check("br_a_if_id_flush", a_if_id_flush, 1);
        check("br_a_id_exe_flush", a_id_exe_flush, 1);
        check("br_a_no_pc_hold", a_pc_hold, 0);
        check("br_b_no_bubble", b_id_exe_bubble, 0);
        check("br_b_id_exe_flush", b_id_exe_flush, 1);
        tick();
        clear_inputs();
        #1;
        check("br_a_state_flush", a_state, 3);
        check("br_a_if_id_flush1", a_if_id_flush, 1);
        check("br_a_id_exe_flush1", a_id_exe_flush, 0);
        check("br_b_state_run", b_state, 0);
        check("br_b_no_flush1", b_if_id_flush, 0);
        tick();
        check("br_a_state_run", a_state, 0);
        check("br_a_stall_count", a_stall_count, 1);

        // ---------------- Busywait from RUN (branch suppressed) ----------------
        dmem_busywait = 1'b1;
        branch_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bw_freeze", a_freeze, 1);
            check("bw_no_flush", a_if_id_flush, 0);
            check("bw_no_hold", a_pc_hold, 0);
            if (k > 0) check("bw_state", a_state, 2);
            tick();
        end
        clear_inputs();
        #1;
        check("bw_rel_state", a_state, 2);
        check("bw_rel_freeze", a_freeze, 0);
        tick();
        check("bw_run_state", a_state, 0);
        check("bw_a_stall_count", a_stall_count, 5);
        check("bw_b_no_timeout", b_timeout_err, 0);

        // ---------------- Busywait during FLUSH ----------------
        branch_taken = 1'b1;
        #1;
        tick();
        clear_inputs();
        imem_busywait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bwf_freeze", a_freeze, 1);
            check("bwf_state", a_state, 3);
            check("bwf_no_flush", a_if_id_flush, 0);
            tick();
        end
        clear_inputs();
        #1;
        check("bwf_rel_state", a_state, 3);
        check("bwf_rel_if_id_flush", a_if_id_flush, 1);
        check("bwf_rel_id_exe_flush", a_id_exe_flush, 0);
        tick();
        check("bwf_run_state", a_state, 0);
        check("bwf_run_no_flush", a_if_id_flush, 0);
        check("bwf_a_stall_count", a_stall_count, 8);

        // ---------------- Timeout (dut_b, MEM_TIMEOUT=5) ----------------
        dmem_busywait = 1'b1;
        #1;
        check("to_before", b_timeout_err, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_flag", b_timeout_err, (i >= 4) ? 1 : 0);
        end
        clear_inputs();
        #1;
        check("to_rel_freeze", b_freeze, 0);
        check("to_sticky", b_timeout_err, 1);
        tick();
        check("to_sticky2", b_timeout_err, 1);
        check("to_b_state", b_state, 0);
        check("to_a_no_timeout", a_timeout_err, 0);
        check("to_a_stall_count", a_stall_count, 16);
        check("to_b_stall_count", b_stall_count, 18);

        // ---------------- Async reset mid-LU_STALL (dut_b) ----------------
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_rd = 5'd3;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        #1;
        check("ar_hit_pc_hold", b_pc_hold, 1);
        tick();
        clear_inputs();
        #1;
        check("ar_b_state_stall", b_state, 1);
        check("ar_b_pc_hold", b_pc_hold, 1);
        check("ar_b_stall_count", b_stall_count, 19);
        #1;
        rst = 1'b1;
        #1;
        check("ar_b_state", b_state, 0);
        check("ar_b_pc_hold_off", b_pc_hold, 0);
        check("ar_b_bubble_off", b_id_exe_bubble, 0);
        check("ar_b_stall_count0", b_stall_count, 0);
        check("ar_b_timeout0", b_timeout_err, 0);
        check("ar_a_stall_count0", a_stall_count, 0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_after_state", b_state, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
